irq_prio_ctrl: RTL and testbench
================================

Name: irq_prio_ctrl

Overview:
- Parametrised N-channel interrupt controller; successor of the single-line irq controller in riscv_unit.
- Sits between peripheral interrupt lines and the core's CSR/trap logic.
- Per-channel masking; per-channel level or edge mode selected at elaboration.
- Fixed priority, lowest index wins; one interrupt in service at a time; one-hot acknowledge back to the source on mret.

Parameters:
N_IRQ, 16, number of interrupt channels (legal 1..32)
EDGE_MASK, 32'h0, bit i = 1 -> channel i edge-triggered (rising); 0 -> level-high
CAUSE_BASE, 16, mcause code of channel 0; channel i reports CAUSE_BASE+i
ID_W, max(1,$clog2(N_IRQ)), derived, width of channel id (localparam)

Ports:
clk_i  in  1  system clock, all state on rising edge
resetn_i  in  1  asynchronous active-low reset
irq_req_i  in  N_IRQ  raw interrupt requests, synchronous to clk_i
irq_mask_i  in  N_IRQ  per-channel enable (mie CSR); 1 = enabled
mie_i  in  1  global interrupt enable (mstatus.MIE)
irq_ret_i  in  1  one-cycle pulse: core executed mret
irq_o  out  1  one-cycle pulse: core must take the interrupt
irq_cause_o  out  32  mcause value for the accepted interrupt
irq_ack_o  out  N_IRQ  one-hot, one-cycle acknowledge to the serviced source
busy_o  out  1  high while an interrupt is in service

Behaviour:
- Reset (async, resetn_i=0):
  - state=IDLE.
  - irq_o=0, irq_cause_o=0, irq_ack_o=0, busy_o=0.
  - All edge pending bits cleared; previous-sample register cleared.
  - Reset mid-service drops the in-service interrupt with no ack.
- Edge detect: prev register holds irq_req_i from the previous cycle. rise[i] = EDGE_MASK[i] & irq_req_i[i] & ~prev[i].
- Pending for edge channels:
  - pend[i] is set by rise[i].
  - pend[i] is cleared only when channel i is accepted.
  - Pending is set regardless of mask, so a masked edge is remembered until unmasked.
- Request per channel:
  - Level channel: req[i] = irq_req_i[i].
  - Edge channel: req[i] = pend[i] | rise[i].
- Eligibility: elig = req & irq_mask_i. Selection is the lowest-index set bit of elig.
- FSM IDLE:
  - If mie_i & |elig at an edge: next cycle irq_o=1 (single cycle), busy_o=1, state=SERV.
  - The selected id is captured; irq_cause_o = {1'b1, 31'(CAUSE_BASE+id)}.
  - If the selected channel is edge-mode, its pend bit is cleared in the same update. This consumes both a latched pend and a coincident rise.
  - Latency: request sampled at edge k -> irq_o high in the cycle after edge k, for both modes.
  - irq_ret_i in IDLE is ignored.
- FSM SERV:
  - No further irq_o. Edge pend bits keep latching, including a new rise on the in-service channel.
  - Changes to mask or mie_i do not abort service.
  - irq_cause_o is held stable.
  - On irq_ret_i: next cycle irq_ack_o[id]=1 for one cycle, busy_o=0, state=IDLE.
  - irq_cause_o keeps its last value until the next acceptance.
- Back-to-back: the new selection is evaluated in IDLE starting the cycle after the ack cycle. Minimum spacing from the ack pulse to the next irq_o is 1 idle cycle.
- Level channel still high after ack: it is re-taken. The source must deassert on irq_ack_o.
- mie_i=0: blocks acceptance only; pending state is unaffected.
- All outputs are registered. There is no combinational path from any input to any output.

Decomposition:
- Package irq_pkg:
  - typedef enum logic {IDLE, SERV} irq_state_t.
  - localparam MCAUSE_INT_BIT = 31.
  - localparam DEFAULT_CAUSE_BASE = 16.
  - Function for the cause word.
- Sub-module irq_prio_enc:
  - Parametrised N -> lowest-index priority encoder.
  - Combinational outputs: valid, id[ID_W-1:0], onehot[N-1:0].
  - Reused by later CLIC/vectored variants.

Test Plan (N_IRQ=16, EDGE_MASK=16'hFF00, CAUSE_BASE=16):
- Level, single: mask=FFFF, mie=1, irq_req_i[3]=1 at edge k -> irq_o pulse in cycle k+1, irq_cause_o=32'h8000_0013, busy_o=1. irq_ret_i pulse -> irq_ack_o=16'h0008 for one cycle; deassert req -> no further irq_o.
- Priority: irq_req_i[5] and [2] high together -> cause 32'h8000_0012 first. After ret/ack(0004) and [2] dropped -> cause 32'h8000_0015, ack 16'h0020.
- Edge latch while masked: 1-cycle pulse on irq_req_i[9] with mask[9]=0 -> no irq_o. Set mask[9]=1 20 cycles later -> irq_o next cycle, cause 32'h8000_0019. After ack, no re-trigger.
- Edge during service: in SERV for ch 8, pulse irq_req_i[8] again -> after ret/ack, irq_o for ch 8 again (cause 32'h8000_0018) two cycles after the ack cycle.
- Gating: mie_i=0 with irq_req_i[0]=1 for 10 cycles -> irq_o stays 0. Set mie_i=1 -> irq_o next cycle. irq_ret_i in IDLE -> irq_ack_o stays 0.
- Async reset mid-SERV: drop resetn_i between edges -> busy_o, irq_cause_o, irq_ack_o, pend all 0 immediately; no ack after release.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and helpers for the priority interrupt controller family.
// Holds the service-state encoding and the mcause word builder.
package irq_pkg;

  typedef enum logic {
    IDLE,
    SERV
  } irq_state_t;

  localparam int MCAUSE_INT_BIT     = 31;
  localparam int DEFAULT_CAUSE_BASE = 16;

  // Interrupt mcause: top bit flags an interrupt, low bits carry base+id.
  function automatic logic [31:0] irq_cause(input int base, input logic [31:0] id);
    logic [31:0] code;
    code = base + id;
    return {1'b1, code[MCAUSE_INT_BIT-1:0]};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder, shared with the vectored/CLIC variants.
// Purely combinational: valid flag, binary id and one-hot of the winner.
module irq_prio_enc #(
  parameter int N    = 16,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  output logic            valid,
  output logic [ID_W-1:0] id,
  output logic [N-1:0]    onehot
);

  // Scan from the top so the lowest set index is the last one written.
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id = ID_W'(i);
      end
    end
  end

  assign onehot = req & (~req + N'(1));
  assign valid  = |req;

endmodule

// File: rtl/irq_prio_ctrl.sv
// N-channel fixed-priority interrupt controller between peripheral lines and the
// core trap logic: masking, level/edge channels, one in service, one-hot ack on mret.
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter int          N_IRQ      = 16,
  parameter logic [31:0] EDGE_MASK  = 32'h0,
  parameter int          CAUSE_BASE = DEFAULT_CAUSE_BASE
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] irq_mask_i,
  input  logic             mie_i,
  input  logic             irq_ret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] irq_ack_o,
  output logic             busy_o
);

  localparam int               ID_W     = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [N_IRQ-1:0] EDGE_SEL = EDGE_MASK[N_IRQ-1:0];

  irq_state_t       state_q;
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] pend_q;
  logic [N_IRQ-1:0] ack_q;
  logic [ID_W-1:0]  id_q;
  logic [31:0]      cause_q;
  logic             irq_q;
  logic             busy_q;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] req;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] sel_onehot;
  logic [ID_W-1:0]  sel_id;
  logic             sel_valid;
  logic             accept;

  assign rise = EDGE_SEL & irq_req_i & ~prev_q;
  assign req  = (EDGE_SEL & (pend_q | rise)) | (~EDGE_SEL & irq_req_i);
  assign elig = req & irq_mask_i;

  irq_prio_enc #(
    .N    (N_IRQ),
    .ID_W (ID_W)
  ) u_enc (
    .req    (elig),
    .valid  (sel_valid),
    .id     (sel_id),
    .onehot (sel_onehot)
  );

  // The ack cycle is excluded so a re-asserted source always sees one idle cycle.
  assign accept = (state_q == IDLE) && mie_i && sel_valid && (ack_q == '0);

  // Edge history and pending latches; the winner's pend is consumed on acceptance.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      prev_q <= irq_req_i;
      pend_q <= (pend_q | rise) & ~(accept ? (sel_onehot & EDGE_SEL) : '0);
    end
  end

  // Service FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
      ack_q   <= '0;
      id_q    <= '0;
      cause_q <= '0;
    end else begin
      irq_q <= 1'b0;
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= SERV;
            irq_q   <= 1'b1;
            busy_q  <= 1'b1;
            id_q    <= sel_id;
            cause_q <= irq_cause(CAUSE_BASE, 32'(sel_id));
          end
        end
        SERV: begin
          if (irq_ret_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= N_IRQ'(1) << id_q;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o       = irq_q;
  assign irq_cause_o = cause_q;
  assign irq_ack_o   = ack_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Bench for irq_prio_ctrl: directed scenarios with fixed expectations, then a
// randomized run checked against a behavioural model of the controller.
module tb_irq_prio_ctrl;

  localparam int          N  = 16;
  localparam logic [31:0] EM = 32'h0000_FF00;
  localparam int          CB = 16;

  logic          clk_i = 1'b0;
  logic          resetn_i;
  logic [N-1:0]  irq_req_i;
  logic [N-1:0]  irq_mask_i;
  logic          mie_i;
  logic          irq_ret_i;
  logic          irq_o;
  logic [31:0]   irq_cause_o;
  logic [N-1:0]  irq_ack_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  logic [31:0]   edge_cfg = EM;
  logic [N-1:0]  m_prev, m_pend, m_ack;
  logic          m_busy, m_irq;
  int            m_id;
  logic [31:0]   m_cause;

  irq_prio_ctrl #(
    .N_IRQ      (N),
    .EDGE_MASK  (EM),
    .CAUSE_BASE (CB)
  ) dut (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .irq_req_i   (irq_req_i),
    .irq_mask_i  (irq_mask_i),
    .mie_i       (mie_i),
    .irq_ret_i   (irq_ret_i),
    .irq_o       (irq_o),
    .irq_cause_o (irq_cause_o),
    .irq_ack_o   (irq_ack_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_prev  = '0;
    m_pend  = '0;
    m_ack   = '0;
    m_busy  = 1'b0;
    m_irq   = 1'b0;
    m_id    = 0;
    m_cause = '0;
  endtask

  // One clock of the controller's behaviour, from the current inputs.
  task automatic model_step();
    logic [N-1:0] rise, want;
    logic         after_ack;
    int           sel;
    after_ack = (m_ack != '0);
    for (int i = 0; i < N; i++) begin
      rise[i] = edge_cfg[i] && irq_req_i[i] && !m_prev[i];
      want[i] = edge_cfg[i] ? (m_pend[i] || rise[i]) : irq_req_i[i];
    end
    m_pend = m_pend | rise;
    m_irq  = 1'b0;
    m_ack  = '0;
    if (!m_busy) begin
      if (mie_i && !after_ack) begin
        sel = -1;
        for (int i = N - 1; i >= 0; i--) if (want[i] && irq_mask_i[i]) sel = i;
        if (sel >= 0) begin
          m_busy  = 1'b1;
          m_irq   = 1'b1;
          m_id    = sel;
          m_cause = 32'h8000_0000 + CB + sel;
          if (edge_cfg[sel]) m_pend[sel] = 1'b0;
        end
      end
    end else if (irq_ret_i) begin
      m_ack[m_id] = 1'b1;
      m_busy      = 1'b0;
    end
    m_prev = irq_req_i;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({irq_o, busy_o, irq_ack_o, irq_cause_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got irq=%0b busy=%0b ack=%h cause=%h want all zero",
               irq_o, busy_o, irq_ack_o, irq_cause_o);
    end
    @(negedge clk_i);
    resetn_i = 1'b1;
    tick();
    checks++;
    if (irq_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got irq=%0b busy=%0b want 0 0", irq_o, busy_o);
    end
  endtask

  task automatic test_level_single();
    int extra;
    irq_mask_i = '1;
    mie_i      = 1'b1;
    irq_req_i  = 16'h0008;
    tick();
    checks++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0013 || busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL level_take: got irq=%0b cause=%h busy=%0b want 1 80000013 1",
               irq_o, irq_cause_o, busy_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL level_single_pulse: got irq=%0b busy=%0b want 0 1", irq_o, busy_o);
    end
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    checks++;
    if (irq_ack_o !== 16'h0008 || busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL level_ack: got ack=%h busy=%0b want 0008 0", irq_ack_o, busy_o);
    end
    irq_req_i = '0;
    tick();
    checks++;
    if (irq_ack_o !== '0) begin
      errors++;
      $display("[TB] FAIL level_ack_width: got ack=%h want 0000", irq_ack_o);
    end
    extra = 0;
    repeat (5) begin
      tick();
      if (irq_o !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL level_no_retake: got %0d irq pulses want 0", extra);
    end
  endtask

  task automatic test_priority();
    irq_req_i = 16'h0024;
    tick();
    checks++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0012) begin
      errors++;
      $display("[TB] FAIL prio_first: got irq=%0b cause=%h want 1 80000012", irq_o, irq_cause_o);
    end
    tick();
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    checks++;
    if (irq_ack_o !== 16'h0004) begin
      errors++;
      $display("[TB] FAIL prio_ack_first: got ack=%h want 0004", irq_ack_o);
    end
    irq_req_i = 16'h0020;
    tick();
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL prio_gap: got irq=%0b want 0", irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0015) begin
      errors++;
      $display("[TB] FAIL prio_second: got irq=%0b cause=%h want 1 80000015", irq_o, irq_cause_o);
    end
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    checks++;
    if (irq_ack_o !== 16'h0020) begin
      errors++;
      $display("[TB] FAIL prio_ack_second: got ack=%h want 0020", irq_ack_o);
    end
    irq_req_i = '0;
    repeat (3) tick();
  endtask

  task automatic test_edge_masked();
    int extra;
    irq_mask_i = 16'hFDFF;
    irq_req_i  = 16'h0200;
    tick();
    irq_req_i = '0;
    extra = 0;
    repeat (20) begin
      tick();
      if (irq_o !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL edge_masked_quiet: got %0d irq pulses want 0", extra);
    end
    irq_mask_i = '1;
    tick();
    checks++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0019) begin
      errors++;
      $display("[TB] FAIL edge_unmask_take: got irq=%0b cause=%h want 1 80000019", irq_o, irq_cause_o);
    end
    tick();
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    checks++;
    if (irq_ack_o !== 16'h0200) begin
      errors++;
      $display("[TB] FAIL edge_masked_ack: got ack=%h want 0200", irq_ack_o);
    end
    extra = 0;
    repeat (6) begin
      tick();
      if (irq_o !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL edge_no_retrigger: got %0d irq pulses want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    irq_req_i = 16'h0100;
    tick();
    checks++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0018) begin
      errors++;
      $display("[TB] FAIL b2b_first: got irq=%0b cause=%h want 1 80000018", irq_o, irq_cause_o);
    end
    irq_req_i = '0;
    tick();
    irq_req_i = 16'h0100;
    tick();
    irq_req_i = '0;
    tick();
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    checks++;
    if (irq_ack_o !== 16'h0100) begin
      errors++;
      $display("[TB] FAIL b2b_ack: got ack=%h want 0100", irq_ack_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle_gap: got irq=%0b want 0", irq_o);
    end
    tick();
    checks++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0018) begin
      errors++;
      $display("[TB] FAIL b2b_retake: got irq=%0b cause=%h want 1 80000018", irq_o, irq_cause_o);
    end
    tick();
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_gating();
    int extra;
    mie_i     = 1'b0;
    irq_req_i = 16'h0001;
    extra     = 0;
    repeat (10) begin
      tick();
      if (irq_o !== 1'b0 || busy_o !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL gate_blocked: got %0d active cycles want 0", extra);
    end
    mie_i = 1'b1;
    tick();
    checks++;
    if (irq_o !== 1'b1 || irq_cause_o !== 32'h8000_0010) begin
      errors++;
      $display("[TB] FAIL gate_release: got irq=%0b cause=%h want 1 80000010", irq_o, irq_cause_o);
    end
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    irq_req_i = '0;
    repeat (3) tick();
    irq_ret_i = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    extra = 0;
    repeat (3) begin
      if (irq_ack_o !== '0 || irq_o !== 1'b0) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL gate_idle_ret: got %0d ack/irq cycles want 0", extra);
    end
  endtask

  task automatic test_async_reset();
    int extra;
    irq_mask_i = 16'hFBFF;
    irq_req_i  = 16'h0402;
    tick();
    irq_req_i = '0;
    tick();
    checks++;
    if (busy_o !== 1'b1 || irq_cause_o !== 32'h8000_0011) begin
      errors++;
      $display("[TB] FAIL rst_pre_serv: got busy=%0b cause=%h want 1 80000011", busy_o, irq_cause_o);
    end
    #2;
    resetn_i = 1'b0;
    #1;
    model_reset();
    checks++;
    if (busy_o !== 1'b0 || irq_cause_o !== '0 || irq_ack_o !== '0 || irq_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_immediate: got busy=%0b cause=%h ack=%h irq=%0b want all zero",
               busy_o, irq_cause_o, irq_ack_o, irq_o);
    end
    #2;
    resetn_i   = 1'b1;
    irq_mask_i = '1;
    irq_ret_i  = 1'b1;
    tick();
    irq_ret_i = 1'b0;
    extra = 0;
    repeat (6) begin
      if (irq_ack_o !== '0 || irq_o !== 1'b0 || busy_o !== 1'b0) extra++;
      tick();
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL rst_pend_cleared: got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      irq_req_i  = N'($urandom & $urandom & $urandom);
      irq_mask_i = N'($urandom | $urandom);
      mie_i      = ($urandom_range(0, 9) != 0);
      irq_ret_i  = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (irq_o !== m_irq) begin
        errors++;
        $display("[TB] FAIL rand_irq cyc %0d: got %0b want %0b", c, irq_o, m_irq);
      end
      checks++;
      if (irq_cause_o !== m_cause) begin
        errors++;
        $display("[TB] FAIL rand_cause cyc %0d: got %h want %h", c, irq_cause_o, m_cause);
      end
      checks++;
      if (irq_ack_o !== m_ack) begin
        errors++;
        $display("[TB] FAIL rand_ack cyc %0d: got %h want %h", c, irq_ack_o, m_ack);
      end
      checks++;
      if (busy_o !== m_busy) begin
        errors++;
        $display("[TB] FAIL rand_busy cyc %0d: got %0b want %0b", c, busy_o, m_busy);
      end
    end
    irq_req_i = '0;
    irq_ret_i = 1'b0;
  endtask

  initial begin
    resetn_i   = 1'b0;
    irq_req_i  = '0;
    irq_mask_i = '0;
    mie_i      = 1'b0;
    irq_ret_i  = 1'b0;
    model_reset();
    $display("[TB] starting irq_prio_ctrl bench");
    test_reset();
    test_level_single();
    test_priority();
    test_edge_masked();
    test_back_to_back();
    test_gating();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
